sys_ctrl: RTL and testbench



---
 rtl/sys_ctrl_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 72 +++++++
 rtl/sys_ctrl.sv | 156 +++++++++++++++
 tb/tb_sys_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared types and helpers for the system-control block.
//   rst_state_e  - core reset sequencer states
//   run_state_e  - run/halt/step controller states
//   cnt_width()  - counter width able to hold 0..n-1 (minimum 1 bit)
package sys_ctrl_pkg;

    typedef enum logic [1:0] {
        RstWait,
        RstPulse,
        RstHold,
        RstRun
    } rst_state_e;

    typedef enum logic [1:0] {
        RunRun,
        RunHalt,
        RunStep
    } run_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- 2-flop synchroniser, stability counter,
// debounced level and single-cycle edge pulses.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   raw asynchronous button
//   level    out  debounced level
//   rise     out  1-cycle pulse on debounced 0->1
//   fall     out  1-cycle pulse on debounced 1->0
module btn_debounce
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CntW    = cnt_width(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            sync_val;

    assign sync_val = sync_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_val == level_q) begin
            // Any return to the current level restarts the stability count.
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d = sync_val;
            cnt_d   = '0;
            rise_d  = sync_val;
            fall_d  = ~sync_val;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sys_ctrl.sv
// sys_ctrl: board-level system control -- per-button debounce, power-on and
// button-driven core reset sequencing, and run/halt/single-step control.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn          in   raw buttons, active high
//   btn_level    out  debounced levels
//   btn_press    out  1-cycle pulses on debounced 0->1
//   btn_release  out  1-cycle pulses on debounced 1->0
//   sys_rst      out  core reset, active high
//   core_ce      out  core clock enable
//   halted       out  run controller not in RUN
//   step_busy    out  single step in progress
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned N_BTN         = 2,
    parameter int unsigned STABLE_CYCLES = 65535,
    parameter int unsigned POR_DELAY     = 3840,
    parameter int unsigned POR_PULSE     = 255,
    parameter int unsigned RST_BTN       = 0,
    parameter int unsigned HALT_BTN      = 1,
    parameter int unsigned STEP_BTN      = 1,
    parameter int unsigned STEP_LEN      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             sys_rst,
    output logic             core_ce,
    output logic             halted,
    output logic             step_busy
);

    // ------------------------------------------------------------------
    // Button channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn[i]),
            .level  (btn_level[i]),
            .rise   (btn_press[i]),
            .fall   (btn_release[i])
        );
    end

    // ------------------------------------------------------------------
    // Core reset sequencer
    // ------------------------------------------------------------------
    localparam int unsigned PorMax   = (POR_DELAY > POR_PULSE) ? POR_DELAY : POR_PULSE;
    localparam int unsigned RcW      = cnt_width(PorMax);
    localparam int unsigned WaitLastI  = (POR_DELAY > 0) ? POR_DELAY - 1 : 0;
    localparam int unsigned PulseLastI = (POR_PULSE > 0) ? POR_PULSE - 1 : 0;
    localparam logic [RcW-1:0] WaitLast  = RcW'(WaitLastI);
    localparam logic [RcW-1:0] PulseLast = RcW'(PulseLastI);

    rst_state_e     rst_state_q, rst_state_d;
    logic [RcW-1:0] rst_cnt_q, rst_cnt_d;
    logic           rst_btn;

    assign rst_btn = btn_level[RST_BTN];

    always_comb begin
        rst_state_d = rst_state_q;
        rst_cnt_d   = rst_cnt_q;
        if (rst_btn) begin
            rst_state_d = RstHold;
        end else begin
            unique case (rst_state_q)
                RstWait: begin
                    if (rst_cnt_q == WaitLast) rst_state_d = RstPulse;
                    else                       rst_cnt_d   = rst_cnt_q + 1'b1;
                end
                RstPulse: begin
                    if (rst_cnt_q == PulseLast) rst_state_d = RstRun;
                    else                        rst_cnt_d   = rst_cnt_q + 1'b1;
                end
                RstHold: rst_state_d = RstPulse;
                RstRun:  rst_state_d = RstRun;
            endcase
        end
        // Every state entry starts its count from zero.
        if (rst_state_d != rst_state_q) rst_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_state_q <= RstWait;
            rst_cnt_q   <= '0;
        end else begin
            rst_state_q <= rst_state_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    assign sys_rst = (rst_state_q == RstPulse) || (rst_state_q == RstHold);

    // ------------------------------------------------------------------
    // Run / halt / step controller
    // ------------------------------------------------------------------
    localparam bit          StepEn    = (STEP_LEN > 0);
    localparam int unsigned ScW       = cnt_width(STEP_LEN);
    localparam int unsigned StepLastI = (STEP_LEN > 0) ? STEP_LEN - 1 : 0;
    localparam logic [ScW-1:0] StepLast = ScW'(StepLastI);

    run_state_e     run_state_q, run_state_d;
    logic [ScW-1:0] step_cnt_q, step_cnt_d;
    logic           halt_press, step_press;

    assign halt_press = btn_press[HALT_BTN];
    assign step_press = btn_press[STEP_BTN] && StepEn;

    always_comb begin
        run_state_d = run_state_q;
        step_cnt_d  = step_cnt_q;
        case (run_state_q)
            RunRun: begin
                if (halt_press) run_state_d = RunHalt;
            end
            RunHalt: begin
                // Halt wins over a simultaneous step press.
                if (halt_press)      run_state_d = RunRun;
                else if (step_press) run_state_d = RunStep;
            end
            RunStep: begin
                if (halt_press)                  run_state_d = RunRun;
                else if (step_cnt_q == StepLast) run_state_d = RunHalt;
                else                             step_cnt_d  = step_cnt_q + 1'b1;
            end
            default: run_state_d = RunRun;
        endcase
        if (run_state_d != run_state_q) step_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_state_q <= RunRun;
            step_cnt_q  <= '0;
        end else begin
            run_state_q <= run_state_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    // Reset forces the enable on so the core actually sees the reset edges.
    assign core_ce   = sys_rst || (run_state_q != RunHalt);
    assign halted    = (run_state_q != RunRun);
    assign step_busy = (run_state_q == RunStep);

endmodule

// File: tb/tb_sys_ctrl.sv
module tb_sys_ctrl;

    localparam int unsigned NB = 3;
    localparam int unsigned SC = 4;
    localparam int unsigned PD = 8;
    localparam int unsigned PP = 4;
    localparam int unsigned SL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          sys_rst, core_ce, halted, step_busy;

    sys_ctrl #(
        .N_BTN        (NB),
        .STABLE_CYCLES(SC),
        .POR_DELAY    (PD),
        .POR_PULSE    (PP),
        .RST_BTN      (0),
        .HALT_BTN     (1),
        .STEP_BTN     (2),
        .STEP_LEN     (SL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sys_rst    (sys_rst),
        .core_ce    (core_ce),
        .halted     (halted),
        .step_busy  (step_busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [12:0] obs;
    assign obs = {btn_level, btn_press, btn_release, sys_rst, core_ce, halted, step_busy};

    // ---------------- behavioural reference model ----------------
    // Buttons: raw value reaches the debouncer two cycles later; a new level
    // is taken after SC consecutive cycles of disagreement.
    // Reset: countdown of PD idle cycles, then PP reset cycles; a held reset
    // button keeps reset asserted and re-arms a PP-cycle tail on release.
    // Run: running flag plus remaining step cycles.
    logic [NB-1:0] m_h1, m_h2, m_lvl, m_press, m_rel;
    int            m_streak [NB];
    int            m_wait, m_pulse, m_step;
    bit            m_hold, m_running;

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < NB; i++) m_streak[i] = 0;
        m_wait = PD; m_pulse = 0; m_hold = 0;
        m_running = 1; m_step = 0;
    endtask

    task automatic model_step();
        logic [NB-1:0] sync, lvl_old, press_old;
        sync = m_h2; lvl_old = m_lvl; press_old = m_press;
        // reset sequencing sees the level as it was before this edge
        if (lvl_old[0]) begin
            m_hold = 1; m_wait = 0; m_pulse = 0;
        end else if (m_hold) begin
            m_hold = 0; m_pulse = PP;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_pulse = PP;
        end else if (m_pulse > 0) begin
            m_pulse--;
        end
        // run control sees last cycle's press pulses
        if (m_step > 0) begin
            if (press_old[1]) begin m_step = 0; m_running = 1; end
            else m_step--;
        end else if (m_running) begin
            if (press_old[1]) m_running = 0;
        end else begin
            if (press_old[1])      m_running = 1;
            else if (press_old[2]) m_step = SL;
        end
        for (int i = 0; i < NB; i++) begin
            m_press[i] = 1'b0; m_rel[i] = 1'b0;
            if (sync[i] == m_lvl[i]) m_streak[i] = 0;
            else if (m_streak[i] == SC - 1) begin
                m_lvl[i] = sync[i]; m_streak[i] = 0;
                m_press[i] = sync[i]; m_rel[i] = ~sync[i];
            end else m_streak[i]++;
        end
        m_h2 = m_h1; m_h1 = btn;
    endtask

    function automatic logic [12:0] exp_vec();
        logic sr;
        sr = m_hold || (m_pulse > 0);
        return {m_lvl, m_press, m_rel, sr, sr || m_running || (m_step > 0),
                !m_running, m_step > 0};
    endfunction

    // One clock: drive at the falling edge, step model at the rising edge,
    // return at the next falling edge ready for sampling.
    task automatic cyc(input logic [NB-1:0] v);
        btn = v;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first, cnt, ce_low;
        rst_n = 1'b0; btn = '0; model_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if (obs !== 13'b0000000000100)
            $display("FAIL reset_values: got %b want %b", obs, 13'b0000000000100);
        else n_pass++;
        rst_n = 1'b1;
        first = -1; cnt = 0; ce_low = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc('0);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL por c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (sys_rst) begin cnt++; if (first < 0) first = c; end
            if (!core_ce) ce_low++;
        end
        n_total++;
        if (first !== 8 || cnt !== 4 || ce_low !== 0)
            $display("FAIL por_shape: first=%0d len=%0d ce_low=%0d want 8 4 0",
                     first, cnt, ce_low);
        else n_pass++;
    endtask

    task automatic test_debounce();
        int press_at, presses;
        logic [NB-1:0] v;
        press_at = -1; presses = 0;
        for (int c = 1; c <= 24; c++) begin
            v = (c <= 2 || (c >= 5 && c <= 14)) ? 3'b010 : 3'b000;
            cyc(v);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL debounce c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (btn_press[1]) begin presses++; if (press_at < 0) press_at = c; end
            if (c == 14) begin
                n_total++;
                if (btn_level[1] !== 1'b1) $display("FAIL debounce_level: got %b want 1", btn_level[1]);
                else n_pass++;
            end
        end
        n_total++;
        if (press_at !== 10 || presses !== 1)
            $display("FAIL debounce_press: at=%0d count=%0d want 10 1", press_at, presses);
        else n_pass++;
    endtask

    // Starts halted (left so by the debounce press).
    task automatic test_halt_toggle();
        for (int c = 1; c <= 32; c++) begin
            cyc((((c - 1) % 16) < 8) ? 3'b010 : 3'b000);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL halt c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (c == 6 || c == 7 || c == 22 || c == 23) begin
                n_total++;
                if ({halted, core_ce} !== ((c == 7 || c == 22) ? 2'b01 : 2'b10))
                    $display("FAIL halt_timing c%0d: halted/ce got %b", c, {halted, core_ce});
                else n_pass++;
            end
        end
    endtask

    // Starts halted.
    task automatic test_step();
        int busy, ce_hi, bad;
        busy = 0; ce_hi = 0; bad = 0;
        for (int c = 1; c <= 16; c++) begin
            cyc((c <= 8) ? 3'b100 : 3'b000);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL step c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (step_busy) busy++;
            if (core_ce) ce_hi++;
            if (core_ce !== step_busy) bad++;
        end
        n_total++;
        if (busy !== 3 || ce_hi !== 3 || bad !== 0 || core_ce !== 1'b0)
            $display("FAIL step_len: busy=%0d ce=%0d bad=%0d end_ce=%b want 3 3 0 0",
                     busy, ce_hi, bad, core_ce);
        else n_pass++;
        // resume, then a step press while running must do nothing
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            cyc((c <= 8) ? 3'b010 : ((c > 16 && c <= 24) ? 3'b100 : 3'b000));
            n_total++;
            if (obs !== exp_vec()) $display("FAIL step_run c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (c > 16 && (step_busy || halted)) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL step_in_run: %0d cycles busy/halted want 0", bad);
        else n_pass++;
    endtask

    // Starts running.
    task automatic test_simultaneous();
        int busy;
        busy = 0;
        for (int c = 1; c <= 32; c++) begin
            cyc((c <= 8) ? 3'b010 : ((c > 16 && c <= 24) ? 3'b110 : 3'b000));
            n_total++;
            if (obs !== exp_vec()) $display("FAIL simul c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (step_busy) busy++;
        end
        n_total++;
        if (busy !== 0 || halted !== 1'b0)
            $display("FAIL simul_result: busy=%0d halted=%b want 0 0", busy, halted);
        else n_pass++;
    endtask

    // Starts running: halt, then a button reset.
    task automatic test_button_reset();
        int rst_cnt, bad;
        for (int c = 1; c <= 16; c++) begin
            cyc((c <= 8) ? 3'b010 : 3'b000);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL btnrst_halt c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
        end
        rst_cnt = 0; bad = 0;
        for (int c = 1; c <= 24; c++) begin
            cyc((c <= 10) ? 3'b001 : 3'b000);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL btnrst c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (sys_rst) begin
                rst_cnt++;
                if (!core_ce || !halted) bad++;
            end
        end
        n_total++;
        if (rst_cnt !== 14 || bad !== 0 || halted !== 1'b1 || core_ce !== 1'b0)
            $display("FAIL btnrst_shape: len=%0d bad=%0d halted=%b ce=%b want 14 0 1 0",
                     rst_cnt, bad, halted, core_ce);
        else n_pass++;
    endtask

    task automatic test_por_interrupt();
        int first, last, cnt;
        @(negedge clk);
        rst_n = 1'b0; btn = '0; model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            cyc((c >= 5 && c <= 12) ? 3'b001 : 3'b000);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL porint c%0d: got %b want %b", c, obs, exp_vec());
            else n_pass++;
            if (sys_rst) begin cnt++; last = c; if (first < 0) first = c; end
        end
        n_total++;
        if (first !== 8 || last !== 22 || cnt !== 15)
            $display("FAIL porint_shape: first=%0d last=%0d len=%0d want 8 22 15",
                     first, last, cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NB-1:0] v;
        int            len;
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0; model_reset();
                repeat (2) @(negedge clk);
                n_total++;
                if (obs !== exp_vec()) $display("FAIL rand_rst s%0d: got %b want %b", seg, obs, exp_vec());
                else n_pass++;
                rst_n = 1'b1;
            end
            v = NB'($urandom_range(0, 7));
            v[0] = ($urandom_range(0, 7) == 0);
            len = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                cyc(v);
                n_total++;
                if (obs !== exp_vec())
                    $display("FAIL rand s%0d c%0d: got %b want %b", seg, c, obs, exp_vec());
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_halt_toggle();
        test_step();
        test_simultaneous();
        test_button_reset();
        test_por_interrupt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
